// File: rtl/rgb_event_sequencer.sv
// Per-channel RGB sweep sequencers: a rising event edge lights the channel's colour on
// each LED in turn for STEP_CYCLES cycles; channel outputs are OR- or priority-mixed per LED.
module rgb_event_sequencer #(
  parameter int                        NUM_EVENTS   = 3,
  parameter int                        NUM_LEDS     = 4,
  parameter int                        STEP_CYCLES  = 25000000,
  parameter logic [3*NUM_EVENTS-1:0]   EVENT_COLORS = 9'b100_010_001
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic                  mix_mode,
  output logic [NUM_LEDS-1:0]   led_R,
  output logic [NUM_LEDS-1:0]   led_G,
  output logic [NUM_LEDS-1:0]   led_B,
  output logic [NUM_EVENTS-1:0] busy
);

  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int SW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(NUM_LEDS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [NUM_EVENTS-1:0] state_q, state_d;
  logic [NUM_EVENTS-1:0] event_prev_q;
  logic [NUM_EVENTS-1:0] edge_w;
  logic [TW-1:0]         timer_q [NUM_EVENTS];
  logic [TW-1:0]         timer_d [NUM_EVENTS];
  logic [SW-1:0]         step_q  [NUM_EVENTS];
  logic [SW-1:0]         step_d  [NUM_EVENTS];
  logic [NUM_LEDS-1:0]   led_r_q, led_g_q, led_b_q;
  logic [NUM_LEDS-1:0]   led_r_d, led_g_d, led_b_d;

  assign edge_w = event_in & ~event_prev_q;

  // A fresh edge always restarts the sweep, overriding any step or terminal advance.
  always_comb begin
    for (int e = 0; e < NUM_EVENTS; e++) begin
      state_d[e] = state_q[e];
      timer_d[e] = timer_q[e];
      step_d[e]  = step_q[e];
      if (edge_w[e]) begin
        state_d[e] = ST_RUN;
        timer_d[e] = '0;
        step_d[e]  = '0;
      end else if (state_q[e] == ST_RUN) begin
        if (timer_q[e] == TIMER_LAST) begin
          timer_d[e] = '0;
          if (step_q[e] == STEP_LAST) state_d[e] = ST_IDLE;
          else                        step_d[e]  = step_q[e] + 1'b1;
        end else begin
          timer_d[e] = timer_q[e] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    logic [2:0] col;
    logic       hit;
    led_r_d = '0;
    led_g_d = '0;
    led_b_d = '0;
    for (int l = 0; l < NUM_LEDS; l++) begin
      col = '0;
      hit = 1'b0;
      for (int e = 0; e < NUM_EVENTS; e++) begin
        if ((state_q[e] == ST_RUN) && (step_q[e] == SW'(l))) begin
          if (!mix_mode)  col = col | EVENT_COLORS[3*e +: 3];
          else if (!hit)  col = EVENT_COLORS[3*e +: 3];
          hit = 1'b1;
        end
      end
      led_r_d[l] = col[2];
      led_g_d[l] = col[1];
      led_b_d[l] = col[0];
    end
  end

  // Output registers trail the channel state by one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= {NUM_EVENTS{ST_IDLE}};
      event_prev_q <= '1;
      led_r_q      <= '0;
      led_g_q      <= '0;
      led_b_q      <= '0;
      for (int e = 0; e < NUM_EVENTS; e++) begin
        timer_q[e] <= '0;
        step_q[e]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      event_prev_q <= event_in;
      led_r_q      <= led_r_d;
      led_g_q      <= led_g_d;
      led_b_q      <= led_b_d;
      for (int e = 0; e < NUM_EVENTS; e++) begin
        timer_q[e] <= timer_d[e];
        step_q[e]  <= step_d[e];
      end
    end
  end

  assign led_R = led_r_q;
  assign led_G = led_g_q;
  assign led_B = led_b_q;
  assign busy  = state_q;

endmodule

// File: tb/tb_rgb_event_sequencer.sv
// Scoreboard bench for rgb_event_sequencer: an age-based channel model predicts busy and
// LED colours every clock; a negedge monitor pops and compares.
module tb_rgb_event_sequencer;

  localparam int NE = 3;
  localparam int NL = 4;
  localparam int SC = 4;
  localparam logic [3*NE-1:0] COLORS = 9'b100_010_001;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [NE-1:0] event_in = '0;
  logic          mix_mode = 1'b0;
  logic [NL-1:0] led_R, led_G, led_B;
  logic [NE-1:0] busy;

  rgb_event_sequencer #(
    .NUM_EVENTS(NE), .NUM_LEDS(NL), .STEP_CYCLES(SC), .EVENT_COLORS(COLORS)
  ) dut (
    .CLK(CLK), .RST(RST), .event_in(event_in), .mix_mode(mix_mode),
    .led_R(led_R), .led_G(led_G), .led_B(led_B), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NE-1:0] busy;
    logic [NL-1:0] r, g, b;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: age[e] = cycles since the channel's last accepted edge, -1 when idle.
  int            age [NE];
  logic [NE-1:0] prev_m = '1;

  initial for (int e = 0; e < NE; e++) age[e] = -1;

  function automatic void mix_model(input logic mm, output logic [NL-1:0] r,
                                    output logic [NL-1:0] g, output logic [NL-1:0] b);
    logic [2:0] c;
    logic [3*NE-1:0] cols;
    bit found;
    cols = COLORS;
    r = '0; g = '0; b = '0;
    for (int l = 0; l < NL; l++) begin
      c = 3'b000;
      found = 0;
      for (int e = 0; e < NE; e++) begin
        if (age[e] >= 0 && age[e] / SC == l) begin
          if (!mm) c = c | cols[3*e +: 3];
          else if (!found) c = cols[3*e +: 3];
          found = 1;
        end
      end
      r[l] = c[2]; g[l] = c[1]; b[l] = c[0];
    end
  endfunction

  always @(posedge CLK) begin
    exp_t x;
    if (RST) begin
      x.r = '0; x.g = '0; x.b = '0;
      for (int e = 0; e < NE; e++) age[e] = -1;
      prev_m = '1;
    end else begin
      mix_model(mix_mode, x.r, x.g, x.b);
      for (int e = 0; e < NE; e++) begin
        if (event_in[e] && !prev_m[e]) age[e] = 0;
        else if (age[e] >= 0) begin
          age[e] = age[e] + 1;
          if (age[e] >= NL * SC) age[e] = -1;
        end
      end
      prev_m = event_in;
    end
    for (int e = 0; e < NE; e++) x.busy[e] = (age[e] >= 0);
    exp_q.push_back(x);
  end

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  always @(negedge CLK) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      cmp("busy",  8'(busy),  8'(x.busy));
      cmp("led_R", 8'(led_R), 8'(x.r));
      cmp("led_G", 8'(led_G), 8'(x.g));
      cmp("led_B", 8'(led_B), 8'(x.b));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    // Held-high input across reset release must not trigger.
    RST = 1'b1; event_in = 3'b001;
    tick(3);
    RST = 1'b0;
    tick(20);
    cmp("direct_hold_busy", 8'(busy), 8'h00);
    cmp("direct_hold_ledB", 8'(led_B), 8'h00);
    event_in = '0;
    tick(2);

    // Single pulse on channel 0 with absolute timing checks.
    event_in = 3'b001;
    tick(1);
    cmp("direct_busy_after_k", 8'(busy), 8'h01);
    cmp("direct_ledB_after_k", 8'(led_B), 8'h00);
    event_in = '0;
    tick(1);
    cmp("direct_ledB_k1", 8'(led_B), 8'h01);
    tick(14);
    cmp("direct_busy_k15", 8'(busy), 8'h01);
    tick(1);
    cmp("direct_busy_k16", 8'(busy), 8'h00);
    cmp("direct_ledB_k16", 8'(led_B), 8'h08);
    tick(1);
    cmp("direct_ledB_k17", 8'(led_B), 8'h00);
    tick(3);

    // Simultaneous edges, OR then priority.
    for (int m = 0; m < 2; m++) begin
      mix_mode = m[0];
      event_in = 3'b011;
      tick(1);
      event_in = '0;
      tick(1);
      cmp("direct_mix_ledG", 8'(led_G), m == 0 ? 8'h01 : 8'h00);
      cmp("direct_mix_ledB", 8'(led_B), 8'h01);
      tick(20);
    end
    mix_mode = 1'b0;

    // Retrigger channel 2 at step 2.
    event_in = 3'b100; tick(1);
    event_in = '0;     tick(8);
    event_in = 3'b100; tick(1);
    event_in = '0;     tick(1);
    cmp("direct_retrig_ledR", 8'(led_R), 8'h01);
    tick(14);
    cmp("direct_retrig_busy", 8'(busy), 8'h04);
    tick(1);
    cmp("direct_retrig_idle", 8'(busy), 8'h00);
    tick(3);

    // Reset mid-animation.
    event_in = 3'b010; tick(1);
    event_in = '0;     tick(5);
    RST = 1'b1;        tick(1);
    cmp("direct_rst_busy", 8'(busy), 8'h00);
    cmp("direct_rst_ledG", 8'(led_G), 8'h00);
    RST = 1'b0;        tick(20);
    cmp("direct_rst_stay", 8'(busy), 8'h00);

    // Randomised traffic: toggling levels, mode flips, occasional reset.
    for (int i = 0; i < 2000; i++) begin
      for (int e = 0; e < NE; e++)
        if ($urandom_range(0, 9) == 0) event_in[e] = ~event_in[e];
      if ($urandom_range(0, 39) == 0) mix_mode = ~mix_mode;
      RST = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    RST = 1'b0; event_in = '0;
    tick(20);
    @(negedge CLK);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
